// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, valid/ready handshakes.
// Define MDU_FAST_MUL_EN to compute multiplies with a single 64-bit multiplier (IDLE -> FIX -> DONE).
module mdu_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_res
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [31:0] r_mag_x, r_mag_y;
  logic        r_sign_x, r_sign_y;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_res;

  // Request decode
  logic        w_x_signed, w_y_signed, w_sx, w_sy;
  logic [31:0] w_mag_x, w_mag_y;
  logic        w_div_zero, w_div_ovf, w_fast_div;
  logic [31:0] w_fast_res;

  assign w_x_signed = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
  assign w_y_signed = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);
  assign w_sx       = w_x_signed & i_x[31];
  assign w_sy       = w_y_signed & i_y[31];
  assign w_mag_x    = w_sx ? (~i_x + 32'd1) : i_x;
  assign w_mag_y    = w_sy ? (~i_y + 32'd1) : i_y;

  assign w_div_zero = i_op[2] && (i_y == 32'd0);
  assign w_div_ovf  = ((i_op == 3'b100) || (i_op == 3'b110)) &&
                      (i_x == 32'h8000_0000) && (i_y == 32'hFFFF_FFFF);
  assign w_fast_div = w_div_zero || w_div_ovf;

  // DIV* -> all ones / 0x80000000, REM* -> dividend / zero
  assign w_fast_res = w_div_zero ? (i_op[1] ? i_x : 32'hFFFF_FFFF)
                                 : (i_op[1] ? 32'd0 : 32'h8000_0000);

`ifdef MDU_FAST_MUL_EN
  logic [63:0] w_ext_x, w_ext_y, w_fast_prod;
  assign w_ext_x     = {{32{w_sx}}, i_x};
  assign w_ext_y     = {{32{w_sy}}, i_y};
  assign w_fast_prod = w_ext_x * w_ext_y;
`endif

  // Multiply step: acc = {partial high, remaining multiplier bits}
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_x} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Divide step: acc = {partial remainder, dividend bits shifting into quotient}
  logic [32:0] w_shift, w_diff;
  logic        w_ge;
  logic [63:0] w_div_next;
  assign w_shift    = {r_acc[63:32], r_acc[31]};
  assign w_diff     = w_shift - {1'b0, r_mag_y};
  assign w_ge       = ~w_diff[32];
  assign w_div_next = {(w_ge ? w_diff[31:0] : w_shift[31:0]), r_acc[30:0], w_ge};

  logic [63:0] w_prod;
  logic [31:0] w_quot, w_rem, w_fix_res;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_prod    = r_acc;
    w_quot    = r_acc[31:0];
    w_rem     = r_acc[63:32];
    w_fix_res = 32'd0;
    if (((r_op == 3'b001) || (r_op == 3'b010)) && (r_sign_x ^ r_sign_y))
      w_prod = ~r_acc + 64'd1;
    if (r_sign_x ^ r_sign_y)
      w_quot = ~r_acc[31:0] + 32'd1;
    if (r_sign_x)
      w_rem = ~r_acc[63:32] + 32'd1;
    case (r_op)
      3'b000:                 w_fix_res = w_prod[31:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[63:32];
      3'b100, 3'b101:         w_fix_res = w_quot;
      default:                w_fix_res = w_rem;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_op     <= 3'd0;
      r_mag_x  <= 32'd0;
      r_mag_y  <= 32'd0;
      r_sign_x <= 1'b0;
      r_sign_y <= 1'b0;
      r_cnt    <= 5'd0;
      r_acc    <= 64'd0;
      r_res    <= 32'd0;
    end else if (i_flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_op     <= i_op;
            r_mag_x  <= w_mag_x;
            r_mag_y  <= w_mag_y;
            r_sign_x <= w_sx;
            r_sign_y <= w_sy;
            r_cnt    <= 5'd0;
            if (w_fast_div) begin
              r_res   <= w_fast_res;
              r_state <= DONE;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!i_op[2]) begin
              // Product is already signed-correct; clear signs so FIX leaves it alone
              r_acc    <= w_fast_prod;
              r_sign_x <= 1'b0;
              r_sign_y <= 1'b0;
              r_state  <= FIX;
            end
`endif
            else begin
              r_acc   <= {32'd0, (i_op[2] ? w_mag_x : w_mag_y)};
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31)
            r_state <= FIX;
        end
        FIX: begin
          r_res   <= w_fix_res;
          r_state <= DONE;
        end
        default: begin
          if (i_ready)
            r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_valid = (r_state == DONE);
  assign o_res   = r_res;

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative, handshaked implementation of the RV32M multiply/divide operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It is the multicycle responder the pipeline's execute stage issues M-extension requests to. It trades the single-cycle combinational multiplier/divider for a one-bit-per-cycle datapath. It has a valid/ready request port and a valid/ready response port, and results are bit-identical to the RV32M specification.

## Interface
- No parameters.
- i_clk  in  1  sole clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  request ready; a request is accepted on an edge where i_valid && o_ready.
- i_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_x  in  32  rs1 operand.
- i_y  in  32  rs2 operand.
- i_flush  in  1  kill the in-flight operation and any pending response.
- o_valid  out  1  response valid.
- i_ready  in  1  consumer ready; the response retires on an edge where o_valid && i_ready.
- o_res  out  32  result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset values: state IDLE, o_ready=1, o_valid=0, o_res=0, counter=0.
- o_ready=1 only in IDLE. o_valid=1 only in DONE.
- IDLE:
  - On accept, latch op, the operand magnitudes and the sign flags.
  - Signed-operand rules: x is signed for MULH, MULHSU, DIV and REM; y is signed for MULH, DIV and REM. MUL uses unsigned magnitudes, since its low word does not depend on sign.
  - Fast path, taken in the accept cycle: divisor zero, or DIV/REM with x=0x80000000 and y=0xFFFFFFFF. Result is written directly and the next state is DONE.
    - DIV/DIVU by zero -> 0xFFFFFFFF.
    - REM/REMU by zero -> i_x.
    - DIV overflow -> 0x80000000.
    - REM overflow -> 0.
  - Otherwise the next state is CALC with counter=0.
- CALC: 32 iterations, one per edge, counter 0..31. Leaves for FIX after counter=31.
  - Multiply: shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, MSB first. The 33-bit trial subtract of the divisor from {rem, next dividend bit} sets the quotient bit when the result is non-negative.
- FIX: apply the sign correction, then select the result and go to DONE.
  - Negate the product when sign_x ^ sign_y for MULH/MULHSU.
  - Negate the quotient when sign_x ^ sign_y.
  - Negate the remainder when sign_x.
  - Result select: MUL prod[31:0]; MULH/MULHSU/MULHU prod[63:32]; DIV/DIVU quotient; REM/REMU remainder.
- DONE: o_res and o_valid are held stable until i_ready. On retire, go to IDLE.
- i_flush:
  - Forces IDLE on the next edge from any state, with o_valid=0. o_res keeps its last value.
  - Overrides acceptance: i_valid in the same cycle as i_flush is not accepted.
  - Overrides retirement: a response in DONE is dropped.
- Async reset mid-operation discards everything and returns all outputs to their reset values immediately.

## Timing
- Accept edge is T.
- Iterative path: CALC at edges T+1..T+32, FIX at edge T+33. o_valid=1 after edge T+33, a latency of 33 cycles.
- Fast path: o_valid=1 after edge T, a latency of 1 cycle.
- Retire edge is R (o_valid && i_ready). o_ready=1 after R, so the next accept is R+1 at the earliest. There are no back-to-back accepts.
- Backpressure: o_valid and o_res are unchanged for every cycle i_ready=0.

## Configuration
- MDU_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU compute with a single 64-bit `*` on sign-extended or zero-extended operands.
  - Flow is IDLE -> FIX -> DONE, so o_valid=1 after edge T+1.
  - The divide path is unchanged.
- MDU_FAST_MUL_EN undefined: multiply uses the 32-iteration shift-add path (latency 33 cycles). No multiplier operator is inferred.

## Test plan
- Multiply results, each with o_valid after edge T+33 (T+1 with MDU_FAST_MUL_EN):
  - MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB.
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divide results:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF.
  - REMU 0xFFFFFFFF / 0x10 -> 0xF.
- Fast path, each with o_valid after edge T:
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid -> o_res stable, o_ready=0, i_valid ignored. Raise i_ready -> retire, then o_ready=1 on the next cycle.
- Flush:
  - Assert i_flush at counter=10 -> o_valid never rises and o_ready=1 after the flush edge. A new MUL 3 x 4 then returns 12.
  - Flush in DONE -> the response is dropped.
- Reset: drop i_rst_n mid-CALC -> o_valid=0, o_ready=1, o_res=0 without a clock edge. A subsequent DIVU 100 / 7 -> 14.
